brecv_mcp_fsm: RTL

// - Receive-side (B clock domain) end of the multi-cycle-path (MCP) CDC handshake.
// - The A-side sender holds adata stable and flips the toggle aen_tog once per word.
// - This block synchronizes aen_tog and converts each edge to a one-cycle pulse.
// - It captures adata into bdata and presents it with bvalid until the consumer pulses bload.
// - On bload it flips back_tog, which the A-side synchronizes as its aack.

---
 rtl/brecv_mcp_fsm.sv | 83 ++++++++
 1 files changed

// File: rtl/brecv_mcp_fsm.sv
// Purpose: B-domain receive end of an MCP CDC handshake; captures the held A-side word and acks it with a toggle.
// Latency: an aen_tog change first sampled at edge N shows bvalid=1 and bdata after edge N+SYNC_STAGES.
// Backpressure: a word is held in bdata with bvalid=1 until bload; the A side must wait for back_tog before sending again.
module brecv_mcp_fsm #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic             bclk,
  input  logic             brst,
  input  logic [WIDTH-1:0] adata,
  input  logic             aen_tog,
  input  logic             bload,
  output logic [WIDTH-1:0] bdata,
  output logic             bvalid,
  output logic             back_tog,
  output logic             berr
);

  typedef enum logic {
    WAIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   bpulse;

  // Synchronizer chain on the request toggle plus the edge-detect history flop.
  // Reset value 0 matches the A-side toggle reset, so reset release never fakes a request.
  always_ff @(posedge bclk) begin
    if (brst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], aen_tog};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse for every level change of the synchronized toggle.
  assign bpulse = sync[SYNC_STAGES-1] ^ prev;

  // Handshake FSM with registered data, ack toggle and sticky error.
  // adata is never synchronized: it is only sampled on the pulse edge, when the
  // sender guarantees it has been stable for the whole synchronizer latency.
  always_ff @(posedge bclk) begin
    if (brst) begin
      state    <= WAIT;
      bdata    <= '0;
      back_tog <= 1'b0;
      berr     <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          // bload has no meaning without a held word, so it is ignored here.
          if (bpulse) begin
            bdata <= adata;
            state <= READY;
          end
        end
        READY: begin
          // A new request before the ack is an overrun: flag it and drop the
          // new word so the unaccepted one in bdata is not corrupted.
          if (bpulse) begin
            berr <= 1'b1;
          end
          if (bload) begin
            state    <= WAIT;
            back_tog <= ~back_tog;
          end
        end
        default: begin
          state <= WAIT;
        end
      endcase
    end
  end

  // Valid is a pure decode of the state register, so bload never reaches an output combinationally.
  assign bvalid = (state == READY);

endmodule
